// File: rtl/kd_io_pkg.sv
// rtl/kd_io_pkg.sv - shared lane geometry for the aggregator/disaggregator pair
package kd_io_pkg;

  localparam int DSIZE       = 11;
  localparam int FETCH_WIDTH = 6;
  localparam int WIDE_WIDTH  = DSIZE * FETCH_WIDTH;

  function automatic logic [DSIZE-1:0] lane_sel(input logic [WIDE_WIDTH-1:0] word, input int idx);
    return word[idx*DSIZE +: DSIZE];
  endfunction

endpackage

// File: rtl/disaggregator_if.sv
// rtl/disaggregator_if.sv - wide sender / narrow receiver FIFO-style handshake bundle
interface disaggregator_if #(
  parameter int DATA_WIDTH  = kd_io_pkg::DSIZE,
  parameter int FETCH_WIDTH = kd_io_pkg::FETCH_WIDTH
);

  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data;
  logic                              sender_empty_n;
  logic                              sender_deq;
  logic [DATA_WIDTH-1:0]             receiver_data;
  logic                              receiver_full_n;
  logic                              receiver_enq;

  modport master (
    output sender_data, sender_empty_n, receiver_full_n,
    input  sender_deq, receiver_data, receiver_enq
  );

  modport slave (
    input  sender_data, sender_empty_n, receiver_full_n,
    output sender_deq, receiver_data, receiver_enq
  );

endinterface

// File: rtl/disaggregator.sv
// rtl/disaggregator.sv - unpacks one wide word into fw_r narrow lanes, lane 0 first
module disaggregator #(
  parameter int DATA_WIDTH  = kd_io_pkg::DSIZE,
  parameter int FETCH_WIDTH = kd_io_pkg::FETCH_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  disaggregator_if.slave         bus,
  input  logic                   change_fetch_width,
  input  logic [2:0]             input_fetch_width,
  output logic                   busy
);

  localparam int                   CNT_WIDTH = $clog2(FETCH_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] FW_MAX    = CNT_WIDTH'(FETCH_WIDTH);

  logic [FETCH_WIDTH*DATA_WIDTH-1:0] buf_r;
  logic [CNT_WIDTH-1:0]              count_r;
  logic [CNT_WIDTH-1:0]              fw_r;
  logic [CNT_WIDTH-1:0]              fw_req;
  logic                              load_cycle;
  logic                              deq;
  logic                              enq;

  // Refill on the last lane's enq keeps the narrow side at one lane per cycle.
  always_comb begin
    load_cycle = change_fetch_width && (count_r == '0);
    enq        = !rst && (count_r != '0) && bus.receiver_full_n;
    deq        = !rst && bus.sender_empty_n && !load_cycle &&
                 ((count_r == '0) || ((count_r == CNT_WIDTH'(1)) && enq));
    if (int'(input_fetch_width) > FETCH_WIDTH) begin
      fw_req = FW_MAX;
    end else begin
      fw_req = CNT_WIDTH'(input_fetch_width);
    end
  end

  assign bus.sender_deq    = deq;
  assign bus.receiver_enq  = enq;
  assign bus.receiver_data = rst ? '0 : buf_r[DATA_WIDTH-1:0];
  assign busy              = !rst && (count_r != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_r   <= '0;
      count_r <= '0;
      fw_r    <= FW_MAX;
    end else begin
      if (load_cycle && (input_fetch_width != 3'd0)) begin
        fw_r <= fw_req;
      end
      if (deq) begin
        buf_r   <= bus.sender_data;
        count_r <= fw_r;
      end else if (enq) begin
        buf_r   <= buf_r >> DATA_WIDTH;
        count_r <= count_r - CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_disaggregator.sv
// tb/tb_disaggregator.sv - directed vector bench for the disaggregator
module tb_disaggregator;
  import kd_io_pkg::*;

  typedef struct {
    logic       rst;
    logic       empty_n;
    int         w_base;
    int         w_n;
    logic       full_n;
    logic       change;
    logic [2:0] ifw;
    logic       deq;
    logic       enq;
    int         data;
    logic       busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       change;
  logic [2:0] ifw;
  logic       busy;
  int         checks = 0;
  int         errors = 0;

  disaggregator_if #(.DATA_WIDTH(DSIZE), .FETCH_WIDTH(FETCH_WIDTH)) bus ();

  disaggregator #(.DATA_WIDTH(DSIZE), .FETCH_WIDTH(FETCH_WIDTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .change_fetch_width (change),
    .input_fetch_width  (ifw),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDE_WIDTH-1:0] mk_word(input int base, input int n);
    logic [WIDE_WIDTH-1:0] w = '0;
    for (int i = 0; i < n; i++) w[i*DSIZE +: DSIZE] = DSIZE'(base + i);
    return w;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Ends one cycle after busy drops, with full_n held high throughout.
  task automatic drain(input logic [WIDE_WIDTH-1:0] w, input int exp_n, input string name);
    int got = 0;
    int guard = 0;
    bus.receiver_full_n = 1'b1;
    @(negedge clk);
    while (busy && guard < 50) begin
      if (bus.receiver_enq) begin
        if (got < FETCH_WIDTH) check({name, "_data"}, int'(bus.receiver_data), int'(lane_sel(w, got)));
        got++;
      end
      next_cycle();
      @(negedge clk);
      guard++;
    end
    check({name, "_lanes"}, got, exp_n);
    next_cycle();
  endtask

  task automatic send_word(input logic [WIDE_WIDTH-1:0] w, input int exp_n, input string name);
    int guard = 0;
    bus.sender_data     = w;
    bus.sender_empty_n  = 1'b1;
    bus.receiver_full_n = 1'b1;
    @(negedge clk);
    while (!bus.sender_deq && guard < 20) begin
      next_cycle();
      @(negedge clk);
      guard++;
    end
    check({name, "_deq"}, int'(bus.sender_deq), 1);
    next_cycle();
    bus.sender_empty_n = 1'b0;
    bus.sender_data    = '0;
    drain(w, exp_n, name);
  endtask

  // Offers a word during the load cycle to confirm the pop is suppressed.
  task automatic set_width(input logic [2:0] v);
    change             = 1'b1;
    ifw                = v;
    bus.sender_empty_n = 1'b1;
    bus.sender_data    = mk_word(99, 6);
    @(negedge clk);
    check("load_cycle_deq", int'(bus.sender_deq), 0);
    next_cycle();
    change             = 1'b0;
    bus.sender_empty_n = 1'b0;
  endtask

  vec_t tbl[26];

  initial begin
    logic [DSIZE-1:0] prev_data;
    logic             stalled;
    logic             last_deq;
    int               got;
    int               guard;

    tbl[0]  = '{1'b1, 1'b0, 0,  0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 0,  1'b0};
    tbl[1]  = '{1'b0, 1'b0, 0,  0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 0,  1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1,  2, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 0,  1'b0};
    tbl[3]  = '{1'b0, 1'b0, 0,  0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1,  1'b1};
    tbl[4]  = '{1'b0, 1'b0, 0,  0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 2,  1'b1};
    tbl[5]  = '{1'b0, 1'b0, 0,  0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 0,  1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1,  2, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 0,  1'b0};
    tbl[7]  = '{1'b0, 1'b1, 3,  2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1,  1'b1};
    tbl[8]  = '{1'b0, 1'b1, 3,  2, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 2,  1'b1};
    tbl[9]  = '{1'b0, 1'b1, 5,  2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3,  1'b1};
    tbl[10] = '{1'b0, 1'b1, 5,  2, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 4,  1'b1};
    tbl[11] = '{1'b0, 1'b0, 0,  0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 5,  1'b1};
    tbl[12] = '{1'b0, 1'b0, 0,  0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 6,  1'b1};
    tbl[13] = '{1'b0, 1'b0, 0,  0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 0,  1'b0};
    tbl[14] = '{1'b0, 1'b1, 7,  2, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 0,  1'b0};
    tbl[15] = '{1'b0, 1'b0, 0,  0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 7,  1'b1};
    tbl[16] = '{1'b0, 1'b0, 0,  0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 7,  1'b1};
    tbl[17] = '{1'b0, 1'b0, 0,  0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 7,  1'b1};
    tbl[18] = '{1'b0, 1'b0, 0,  0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8,  1'b1};
    tbl[19] = '{1'b0, 1'b1, 9,  2, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 0,  1'b0};
    tbl[20] = '{1'b0, 1'b1, 11, 2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 9,  1'b1};
    tbl[21] = '{1'b0, 1'b1, 11, 2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 10, 1'b1};
    tbl[22] = '{1'b0, 1'b1, 11, 2, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 10, 1'b1};
    tbl[23] = '{1'b0, 1'b0, 0,  0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 11, 1'b1};
    tbl[24] = '{1'b0, 1'b0, 0,  0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 12, 1'b1};
    tbl[25] = '{1'b0, 1'b0, 0,  0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 0,  1'b0};

    for (int i = 0; i < 26; i++) begin
      rst                 = tbl[i].rst;
      bus.sender_empty_n  = tbl[i].empty_n;
      bus.sender_data     = mk_word(tbl[i].w_base, tbl[i].w_n);
      bus.receiver_full_n = tbl[i].full_n;
      change              = tbl[i].change;
      ifw                 = tbl[i].ifw;
      @(negedge clk);
      check($sformatf("v%0d_deq", i),  int'(bus.sender_deq),    int'(tbl[i].deq));
      check($sformatf("v%0d_enq", i),  int'(bus.receiver_enq),  int'(tbl[i].enq));
      check($sformatf("v%0d_data", i), int'(bus.receiver_data), tbl[i].data);
      check($sformatf("v%0d_busy", i), int'(busy),              int'(tbl[i].busy));
      next_cycle();
    end
    check("width2_loaded", int'(dut.fw_r), 2);
    bus.sender_empty_n = 1'b0;
    change             = 1'b0;

    // Width 6 under random backpressure, with a second word waiting behind it.
    set_width(3'd6);
    bus.sender_data     = mk_word(10, 6);
    bus.sender_empty_n  = 1'b1;
    bus.receiver_full_n = 1'b1;
    @(negedge clk);
    check("bp_first_deq", int'(bus.sender_deq), 1);
    next_cycle();
    bus.sender_data = mk_word(20, 6);
    got = 0; guard = 0; stalled = 1'b0; last_deq = 1'b0; prev_data = '0;
    while (got < 6 && guard < 200) begin
      bus.receiver_full_n = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stalled) check("bp_stable", int'(bus.receiver_data), int'(prev_data));
      if (bus.receiver_enq) begin
        check("bp_data", int'(bus.receiver_data), 10 + got);
        got++;
      end
      check("bp_early_deq", int'(bus.sender_deq && got < 6), 0);
      last_deq  = bus.sender_deq;
      prev_data = bus.receiver_data;
      stalled   = busy && !bus.receiver_enq;
      guard++;
      next_cycle();
    end
    check("bp_lanes", got, 6);
    check("bp_refill_deq", int'(last_deq), 1);
    bus.sender_empty_n = 1'b0;
    drain(mk_word(20, 6), 6, "bp_second");

    // Width request while the last lane is pending must be ignored.
    set_width(3'd2);
    bus.sender_data     = mk_word(1, 6);
    bus.sender_empty_n  = 1'b1;
    bus.receiver_full_n = 1'b1;
    @(negedge clk);
    check("mid_deq", int'(bus.sender_deq), 1);
    next_cycle();
    bus.sender_empty_n = 1'b0;
    @(negedge clk);
    check("mid_lane0", int'(bus.receiver_data), 1);
    next_cycle();
    change = 1'b1; ifw = 3'd3; bus.receiver_full_n = 1'b0;
    @(negedge clk);
    check("mid_stall_enq", int'(bus.receiver_enq), 0);
    check("mid_stall_busy", int'(busy), 1);
    next_cycle();
    change = 1'b0; bus.receiver_full_n = 1'b1;
    @(negedge clk);
    check("mid_lane1", int'(bus.receiver_data), 2);
    check("mid_lane1_enq", int'(bus.receiver_enq), 1);
    next_cycle();
    check("mid_fw_kept", int'(dut.fw_r), 2);
    send_word(mk_word(30, 6), 2, "after_ignored");
    set_width(3'd3);
    send_word(mk_word(40, 6), 3, "width3");
    set_width(3'd7);
    send_word(mk_word(50, 6), 6, "width7_clamp");
    set_width(3'd0);
    send_word(mk_word(60, 6), 6, "width0_ignored");

    // Reset after lane 0 of a width-2 word discards the rest and restores width 6.
    set_width(3'd2);
    bus.sender_data     = mk_word(70, 6);
    bus.sender_empty_n  = 1'b1;
    bus.receiver_full_n = 1'b1;
    @(negedge clk);
    check("rst_seq_deq", int'(bus.sender_deq), 1);
    next_cycle();
    bus.sender_empty_n = 1'b0;
    @(negedge clk);
    check("rst_seq_lane0", int'(bus.receiver_data), 70);
    next_cycle();
    rst = 1'b1; bus.sender_empty_n = 1'b1;
    @(negedge clk);
    check("in_rst_deq", int'(bus.sender_deq), 0);
    check("in_rst_enq", int'(bus.receiver_enq), 0);
    check("in_rst_data", int'(bus.receiver_data), 0);
    check("in_rst_busy", int'(busy), 0);
    next_cycle();
    rst = 1'b0; bus.sender_empty_n = 1'b0;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_enq", int'(bus.receiver_enq), 0);
    check("post_rst_fw", int'(dut.fw_r), 6);
    next_cycle();
    send_word(mk_word(80, 6), 6, "post_rst_word");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
